// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer for the Salamander-4 core.
// Fetches instruction words from instruction memory, latches them into the
// instruction register, pulses the ALU and register-file strobes, and drives
// the program counter's increment and load controls. It halts on a HALT
// opcode, or when the program counter overflows during a fetch.
//
// Memory port handshake: mem_req is held high, with mem_addr = pc_val held
// stable, for as long as the sequencer is in a fetch state. A fetch completes
// in the first cycle that has both mem_req and mem_ack high; mem_rdata is
// sampled in that same cycle. mem_ack is ignored whenever mem_req is low.
// pc_max is checked before mem_ack, so an overflow aborts the fetch even if
// the acknowledge arrives in the same cycle.
module pc_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_val,
    input  logic               pc_max,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_load_val,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               zero_flag,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_en,
    output logic               reg_we,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FETCH2 = 3'd5;
    localparam logic [2:0] S_JUMP   = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]        cur_state;
    logic [2:0]        next_state;
    logic [ADDR_W-1:0] target;
    logic [3:0]        opcode;
    logic              fetching;
    logic              take_branch;

    // The opcode stays in ir while the operand word of a jump is fetched.
    assign opcode      = ir[INSTR_W-1:INSTR_W-4];
    assign fetching    = (cur_state == S_FETCH) || (cur_state == S_FETCH2);
    assign take_branch = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag);

    // Strobes decode from the state register; pc_inc follows the completed handshake.
    assign mem_req     = fetching;
    assign mem_addr    = pc_val;
    assign pc_inc      = fetching & mem_ack & ~pc_max;
    assign pc_load     = (cur_state == S_JUMP) & take_branch;
    assign pc_load_val = target;
    assign alu_en      = (cur_state == S_EXEC);
    assign reg_we      = (cur_state == S_WB);
    assign busy        = (cur_state != S_IDLE) && (cur_state != S_HALT);
    assign halted      = (cur_state == S_HALT);
    assign state       = cur_state;

    // Next-state selection for the fetch/decode/execute sequence.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_IDLE, S_HALT: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (pc_max)       next_state = S_HALT;
                else if (mem_ack) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT:       next_state = S_HALT;
                    OP_NOP:        next_state = S_FETCH;
                    OP_JMP, OP_JZ: next_state = S_FETCH2;
                    default:       next_state = S_EXEC;
                endcase
            end
            S_EXEC:   next_state = S_WB;
            S_WB:     next_state = S_FETCH;
            S_FETCH2: begin
                if (pc_max)       next_state = S_HALT;
                else if (mem_ack) next_state = S_JUMP;
            end
            S_JUMP:   next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // State register; reset returns to IDLE immediately, dropping mem_req.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cur_state <= S_IDLE;
        else       cur_state <= next_state;
    end

    // Instruction register loads only on a completed opcode fetch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              ir <= '0;
        else if ((cur_state == S_FETCH) && pc_inc) ir <= mem_rdata;
    end

    // Jump target loads only on a completed operand fetch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                  target <= '0;
        else if ((cur_state == S_FETCH2) && pc_inc) target <= mem_rdata[ADDR_W-1:0];
    end

    // Sticky overflow flag: set by an overflow halt, cleared when restarting from HALT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             err <= 1'b0;
        else if (fetching && pc_max)           err <= 1'b1;
        else if ((cur_state == S_HALT) && start) err <= 1'b0;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: an instruction-level model generates per-cycle
// input vectors and expected output vectors; one executor drives and compares.
module tb_pc_sequencer;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 8;
  localparam int EW      = 26;
  localparam logic [7:0] JUNK = 8'hA5;

  typedef struct packed {
    logic       start;
    logic       ack;
    logic       pcmax;
    logic       zf;
    logic [7:0] rdata;
  } in_t;

  // clock / reset / DUT signals
  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [ADDR_W-1:0]  pc_val;
  logic               pc_max;
  logic               pc_inc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               zero_flag;
  logic [INSTR_W-1:0] ir;
  logic               alu_en;
  logic               reg_we;
  logic               busy;
  logic               halted;
  logic               err;
  logic [2:0]         dbg_state;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pc_val(pc_val), .pc_max(pc_max),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .zero_flag(zero_flag), .ir(ir), .alu_en(alu_en),
    .reg_we(reg_we), .busy(busy), .halted(halted), .err(err), .state(dbg_state)
  );

  // scoreboard
  in_t             in_q[$];
  logic [EW-1:0]   exp_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              cyc      = 0;

  // model state (instruction level)
  logic [ADDR_W-1:0]  m_pc;
  logic [ADDR_W-1:0]  m_target;
  logic [INSTR_W-1:0] m_ir;
  logic               m_err;
  logic               m_halted;

  // program-counter environment, updated from DUT strobes
  logic               pend_inc;
  logic               pend_load;
  logic [ADDR_W-1:0]  pend_val;

  function automatic logic [EW-1:0] pack_out(
    input logic req, input logic [ADDR_W-1:0] addr, input logic inc,
    input logic load, input logic [ADDR_W-1:0] lval, input logic alu,
    input logic we, input logic bsy, input logic hlt, input logic er,
    input logic [INSTR_W-1:0] irv);
    return {req, addr, inc, load, lval, alu, we, bsy, hlt, er, irv};
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return pack_out(mem_req, mem_addr, pc_inc, pc_load, pc_load_val,
                    alu_en, reg_we, busy, halted, err, ir);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic apply_pc();
    if (pend_inc)       pc_val = pc_val + 1'b1;
    else if (pend_load) pc_val = pend_val;
    pend_inc  = 1'b0;
    pend_load = 1'b0;
  endtask

  // driver: one cycle of inputs, then compare against the expected vector
  task automatic step(input in_t v, input logic [EW-1:0] e);
    @(negedge clk);
    apply_pc();
    start     = v.start;
    mem_ack   = v.ack;
    pc_max    = v.pcmax;
    zero_flag = v.zf;
    mem_rdata = v.rdata;
    #1;
    chk($sformatf("cyc%0d", cyc), 32'(dut_vec()), 32'(e));
    cyc++;
    pend_inc  = pc_inc;
    pend_load = pc_load;
    pend_val  = pc_load_val;
  endtask

  task automatic run_queue();
    in_t           v;
    logic [EW-1:0] e;
    while (in_q.size() > 0) begin
      v = in_q.pop_front();
      e = exp_q.pop_front();
      step(v, e);
    end
  endtask

  // model primitive: record one cycle of inputs and the outputs it must produce
  task automatic emit(input logic st, input logic ack, input logic pm, input logic zf,
                      input logic [7:0] rd, input logic req, input logic inc,
                      input logic load, input logic alu, input logic we,
                      input logic bsy, input logic hlt);
    in_t v;
    v = '{start: st, ack: ack, pcmax: pm, zf: zf, rdata: rd};
    in_q.push_back(v);
    exp_q.push_back(pack_out(req, m_pc, inc, load, m_target, alu, we, bsy, hlt, m_err, m_ir));
  endtask

  // idle cycles in IDLE/HALT; acknowledges are offered but must be ignored
  task automatic m_idle(input int n);
    for (int i = 0; i < n; i++) emit(1'b0, 1'b1, 1'b0, 1'b0, JUNK, 0, 0, 0, 0, 0, 0, m_halted);
  endtask

  task automatic m_start();
    emit(1'b1, 1'b0, 1'b0, 1'b0, JUNK, 0, 0, 0, 0, 0, 0, m_halted);
    m_err    = 1'b0;
    m_halted = 1'b0;
  endtask

  // one memory fetch with `delay` wait cycles; overflow aborts it
  task automatic m_fetch(input int delay, input logic [7:0] word, input logic overflow,
                         input logic operand);
    for (int i = 0; i < delay; i++) emit(1'b0, 1'b0, 1'b0, 1'b0, JUNK, 1, 0, 0, 0, 0, 1, 0);
    if (overflow) begin
      emit(1'b0, 1'b1, 1'b1, 1'b0, word, 1, 0, 0, 0, 0, 1, 0);
      m_err    = 1'b1;
      m_halted = 1'b1;
    end else begin
      emit(1'b0, 1'b1, 1'b0, 1'b0, word, 1, 1, 0, 0, 0, 1, 0);
      m_pc = m_pc + 1'b1;
      if (operand) m_target = word[ADDR_W-1:0];
      else         m_ir     = word;
    end
  endtask

  // one whole instruction, starting in the fetch of its opcode word
  task automatic m_instr(input logic [7:0] word, input int d1,
                         input logic [7:0] operand, input int d2, input logic zf);
    logic [3:0] op;
    logic       take;
    op = word[7:4];
    m_fetch(d1, word, 1'b0, 1'b0);
    emit(1'b0, 1'b1, 1'b0, 1'b0, JUNK, 0, 0, 0, 0, 0, 1, 0);
    if (op == 4'hF) begin
      m_halted = 1'b1;
    end else if (op == 4'h0) begin
      // back to fetch
    end else if (op == 4'hE || op == 4'hD) begin
      m_fetch(d2, operand, 1'b0, 1'b1);
      take = (op == 4'hE) || zf;
      emit(1'b0, 1'b1, 1'b0, zf, JUNK, 0, 0, take, 0, 0, 1, 0);
      if (take) m_pc = m_target;
    end else begin
      emit(1'b0, 1'b1, 1'b0, 1'b0, JUNK, 0, 0, 0, 1, 0, 1, 0);
      emit(1'b0, 1'b1, 1'b0, 1'b0, JUNK, 0, 0, 0, 0, 1, 1, 0);
    end
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b1; pc_val = '0; pc_max = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; zero_flag = 1'b0;
    pend_inc = 1'b0; pend_load = 1'b0; pend_val = '0;
    m_pc = '0; m_target = '0; m_ir = '0; m_err = 1'b0; m_halted = 1'b0;

    // reset with start held high
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_fetch", 32'(dbg_state), 32'h1);
    chk("first_edge_req", 32'(mem_req), 32'h1);

    // ALU op 0x12 at address 0, zero-wait
    m_instr(8'h12, 0, 8'h00, 0, 1'b0);
    run_queue(); apply_pc();
    chk("alu_pc", 32'(pc_val), 32'h1);
    chk("alu_ir", 32'(ir), 32'h12);

    // NOP with three wait cycles
    m_instr(8'h00, 3, 8'h00, 0, 1'b0);
    run_queue(); apply_pc();
    chk("nop_pc", 32'(pc_val), 32'h2);

    // JMP 7
    m_instr(8'hE0, 0, 8'h07, 0, 1'b0);
    run_queue(); apply_pc();
    chk("jmp_pc", 32'(pc_val), 32'h7);
    chk("jmp_target", 32'(pc_load_val), 32'h7);

    // JZ 3, not taken
    m_instr(8'hD0, 0, 8'h03, 1, 1'b0);
    run_queue(); apply_pc();
    chk("jz0_pc", 32'(pc_val), 32'h9);

    // JZ 3, taken
    m_instr(8'hD0, 2, 8'h03, 0, 1'b1);
    run_queue(); apply_pc();
    chk("jz1_pc", 32'(pc_val), 32'h3);

    // HALT, then stay halted without fetching
    m_instr(8'hF0, 0, 8'h00, 0, 1'b0);
    m_idle(3);
    run_queue(); apply_pc();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_pc", 32'(pc_val), 32'h4);

    // restart resumes at the incremented pc
    m_start();
    m_instr(8'h35, 1, 8'h00, 0, 1'b0);
    run_queue(); apply_pc();
    chk("resume_pc", 32'(pc_val), 32'h5);

    // overflow coinciding with an acknowledge
    m_fetch(0, 8'h77, 1'b1, 1'b0);
    m_idle(2);
    run_queue(); apply_pc();
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_ir", 32'(ir), 32'h35);
    chk("ovf_pc", 32'(pc_val), 32'h5);

    // restart clears err; reset lands in the middle of an operand fetch
    m_start();
    m_fetch(0, 8'hE0, 1'b0, 1'b0);
    emit(1'b0, 1'b1, 1'b0, 1'b0, JUNK, 0, 0, 0, 0, 0, 1, 0);
    emit(1'b0, 1'b0, 1'b0, 1'b0, JUNK, 1, 0, 0, 0, 0, 1, 0);
    run_queue(); apply_pc();
    chk("restart_err", 32'(err), 32'h0);
    chk("fetch2_req", 32'(mem_req), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("midreset_req", 32'(mem_req), 32'h0);
    chk("midreset_state", 32'(dbg_state), 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_ir", 32'(ir), 32'h0);
    chk("midreset_pc", 32'(pc_val), 32'h6);
    @(negedge clk);
    rstn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(dbg_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/decode/execute sequencer for the Salamander-4 core. It drives the program counter's increment and load controls, fetches instruction words over a request/acknowledge memory port, latches them into the instruction register, and pulses ALU and register-file enables. It sits between the program counter, the instruction memory and the datapath, and it halts the core on a HALT opcode or on program-counter overflow.

## Interface
- ADDR_W, 5, width of the program counter and the memory address.
- INSTR_W, 8, instruction word width. The opcode is ir[INSTR_W-1:INSTR_W-4].
- clk  in  1  clock. All state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  begins execution from IDLE or HALT. Ignored in all other states.
- pc_val  in  ADDR_W  current program counter value.
- pc_max  in  1  program-counter overflow flag (max_size_reached).
- pc_inc  out  1  program-counter increment strobe.
- pc_load  out  1  program-counter load strobe.
- pc_load_val  out  ADDR_W  jump target presented with pc_load.
- mem_req  out  1  instruction-fetch request.
- mem_addr  out  ADDR_W  fetch address. Equals pc_val while mem_req=1.
- mem_ack  in  1  fetch acknowledge. mem_rdata is valid in the same cycle.
- mem_rdata  in  INSTR_W  fetched word.
- zero_flag  in  1  ALU zero flag, used by JZ.
- ir  out  INSTR_W  instruction register.
- alu_en  out  1  one-cycle ALU execute strobe.
- reg_we  out  1  one-cycle register-file write strobe.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky flag: halt caused by pc_max.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, FETCH2, JUMP, HALT. Reset state is IDLE.
- IDLE/HALT: start=1 moves to FETCH. Leaving HALT clears err. The PC is not reset; execution resumes at the current pc_val.
- FETCH: mem_req=1.
  - If pc_max=1: go to HALT and set err=1. No pc_inc, ir unchanged. pc_max has priority over mem_ack.
  - Else if mem_ack=1: ir<=mem_rdata, pc_inc=1 in the same cycle, go to DECODE.
  - Else stay in FETCH.
- DECODE (opcode=ir[7:4]):
  - 4'hF HALT: go to HALT.
  - 4'h0 NOP: go to FETCH.
  - 4'hE JMP and 4'hD JZ: go to FETCH2.
  - All other opcodes: go to EXEC.
- EXEC: alu_en=1, go to WB.
- WB: reg_we=1, go to FETCH.
- FETCH2: fetches the operand word with the same rules as FETCH, including pc_max handling.
  - On ack: target<=mem_rdata[ADDR_W-1:0], pc_inc=1, go to JUMP.
  - ir keeps the opcode word.
- JUMP: if JMP, or JZ with zero_flag=1 sampled this cycle, then pc_load=1 with pc_load_val=target. Then go to FETCH.
- pc_load_val is driven with target at all times. It is meaningful only while pc_load=1.
- mem_ack is ignored when mem_req=0.
- pc_inc and pc_load are never high together.
- Unused or illegal state encodings recover to IDLE.

## Timing
- mem_req, alu_en, reg_we, pc_load, busy and halted decode from the state register only.
- pc_inc is combinational: mem_req & mem_ack & ~pc_max.
- Zero-wait memory latency (cycles from entering FETCH to re-entering FETCH):
  - NOP: 2.
  - ALU op: 4 (alu_en in cycle 3, reg_we in cycle 4).
  - JMP/JZ: 4.
- Each cycle of mem_ack delay adds one cycle. mem_addr holds stable until ack.
- Reset values: every output 0, ir=0, target=0, err=0, state IDLE.
- rstn low in any state returns to IDLE at once. mem_req drops asynchronously; no partial pc_inc.

## Test plan
- Reset with start=1 held through reset → all outputs 0, state IDLE. First edge after release enters FETCH.
- Word 0x12 at address 0, zero-wait → pc_inc at cycle 1 (pc 0→1), ir=0x12, alu_en at cycle 3, reg_we at cycle 4, then mem_req again at address 1.
- mem_ack delayed 3 cycles on 0x00 (NOP) → mem_req held 3 cycles with mem_addr constant. Exactly one pc_inc. Back to FETCH 2 cycles after ack.
- Branches:
  - JMP pair 0xE0, 0x07 → two pc_inc, then one cycle pc_load=1 with pc_load_val=7.
  - JZ pair 0xD0, 0x03 with zero_flag=0 → no pc_load.
  - Same JZ pair with zero_flag=1 → pc_load with pc_load_val=3.
- HALT 0xF0 → halted=1, busy=0, no further mem_req. A start pulse then fetches from the incremented pc_val.
- Overflow and mid-fetch reset:
  - pc_max=1 together with mem_ack in FETCH → HALT, err=1, pc_inc=0, ir unchanged. err clears on the next start.
  - rstn asserted mid-FETCH2 → mem_req=0 immediately, state IDLE.
